// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and width helpers for the debounce bank.
//   chan_state_e : per-channel confirm FSM state (stable / confirming).
//   cnt_width()  : bits needed to hold a counter value 0..max_val.
//   max2()       : larger of two values, used to size shared counters.
package debounce_pkg;

  typedef enum logic {
    StStable  = 1'b0,
    StConfirm = 1'b1
  } chan_state_e;

  localparam int unsigned DefTickDiv     = 100000;
  localparam int unsigned DefStableTicks = 10;
  localparam int unsigned DefRepDelay    = 50;
  localparam int unsigned DefRepPeriod   = 20;

  // Counters never need to saturate: they are wide enough for their largest value.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one debounced input channel.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   tick_i  : one-cycle sample strobe from the shared prescaler
//   raw_i   : raw asynchronous switch level
//   db_o    : debounced level
//   rise_o  : one-cycle pulse in the first cycle db_o shows 1
//   fall_o  : one-cycle pulse in the first cycle db_o shows 0
//   rep_o   : pulse on press and, if REP_EN, on each auto-repeat while held
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DefStableTicks,
  parameter int unsigned REP_DELAY    = DefRepDelay,
  parameter int unsigned REP_PERIOD   = DefRepPeriod,
  parameter bit          REP_EN       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o,
  output logic rep_o
);

  localparam int unsigned StW  = cnt_width(STABLE_TICKS);
  localparam int unsigned RepW = cnt_width(max2(REP_DELAY, REP_PERIOD));

  logic            sync1_q, sync_q;
  chan_state_e     state_q, state_d;
  logic [StW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic            accept;
  logic            db_q, db_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            rep_q, rep_d;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_cnt_inc, rep_target;
  logic            rep_arm_q, rep_arm_d;

  assign cnt_inc     = cnt_q + StW'(1);
  assign rep_cnt_inc = rep_cnt_q + RepW'(1);
  // First repeat waits REP_DELAY ticks, later ones REP_PERIOD ticks.
  assign rep_target  = rep_arm_q ? RepW'(REP_PERIOD) : RepW'(REP_DELAY);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync_q    <= 1'b0;
      state_q   <= StStable;
      cnt_q     <= '0;
      db_q      <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      rep_q     <= 1'b0;
      rep_cnt_q <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync_q    <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      rep_q     <= rep_d;
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
    end
  end

  // Next-state: confirm a new level only after STABLE_TICKS differing ticks in a row
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (tick_i) begin
      unique case (state_q)
        StStable: begin
          if (sync_q != db_q) begin
            if (STABLE_TICKS == 1) begin
              accept = 1'b1;
            end else begin
              state_d = StConfirm;
              cnt_d   = StW'(1);
            end
          end
        end
        StConfirm: begin
          if (sync_q == db_q) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_inc == StW'(STABLE_TICKS)) begin
            accept  = 1'b1;
            state_d = StStable;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StStable;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: edges are registered with db so they coincide with the new level
  always_comb begin
    db_d      = accept ? sync_q : db_q;
    rise_d    = accept & sync_q;
    fall_d    = accept & ~sync_q;
    rep_d     = accept & sync_q;
    rep_cnt_d = rep_cnt_q;
    rep_arm_d = rep_arm_q;
    if (accept) begin
      // Any accepted change restarts the repeat schedule; a release also silences it.
      rep_cnt_d = '0;
      rep_arm_d = 1'b0;
    end else if (REP_EN && db_q && tick_i) begin
      if (rep_cnt_inc == rep_target) begin
        rep_d     = 1'b1;
        rep_cnt_d = '0;
        rep_arm_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_inc;
      end
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign rep_o  = rep_q;

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent debounced inputs sharing one sample prescaler.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   raw_i  : raw asynchronous levels, one bit per channel
//   db_o   : debounced levels
//   rise_o : one-cycle pulse per accepted 0->1 change
//   fall_o : one-cycle pulse per accepted 1->0 change
//   rep_o  : pulse on press and on each auto-repeat (channels enabled in REP_MASK)
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned     N_CH         = 9,
  parameter int unsigned     TICK_DIV     = DefTickDiv,
  parameter int unsigned     STABLE_TICKS = DefStableTicks,
  parameter int unsigned     REP_DELAY    = DefRepDelay,
  parameter int unsigned     REP_PERIOD   = DefRepPeriod,
  parameter logic [N_CH-1:0] REP_MASK     = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] raw_i,
  output logic [N_CH-1:0] db_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] rep_o
);

  localparam int unsigned PreW = cnt_width(TICK_DIV - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic            tick;

  assign tick = (pre_q == PreW'(TICK_DIV - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + PreW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .REP_DELAY    (REP_DELAY),
      .REP_PERIOD   (REP_PERIOD),
      .REP_EN       (REP_MASK[i])
    ) u_chan (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick_i (tick),
      .raw_i  (raw_i[i]),
      .db_o   (db_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i]),
      .rep_o  (rep_o[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank with a small tick-level reference model.
module tb_debounce_bank;

  localparam int unsigned N  = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned ST = 3;
  localparam int unsigned RD = 4;
  localparam int unsigned RP = 2;
  localparam logic [3:0]  MASK = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw = '0;
  logic [3:0] db, rise, fall, rep;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  debounce_bank #(
    .N_CH         (N),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .REP_DELAY    (RD),
    .REP_PERIOD   (RP),
    .REP_MASK     (MASK)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .raw_i  (raw),
    .db_o   (db),
    .rise_o (rise),
    .fall_o (fall),
    .rep_o  (rep)
  );

  always #5 clk = ~clk;

  // Reference model: raw seen two clocks late, sampled every TD clocks since reset.
  logic [3:0] m_db, m_rise, m_fall, m_rep;
  logic [3:0] m_hist [2];
  int         m_run  [4];
  int         m_held [4];
  int         m_cyc;

  task automatic model_step(input logic in_reset, input logic [3:0] r);
    logic       tick;
    logic [3:0] smp;
    m_rise = '0;
    m_fall = '0;
    m_rep  = '0;
    if (in_reset) begin
      m_db = '0;
      m_hist[0] = '0;
      m_hist[1] = '0;
      m_cyc = 0;
      for (int c = 0; c < 4; c++) begin
        m_run[c]  = 0;
        m_held[c] = 0;
      end
      return;
    end
    tick = ((m_cyc % TD) == TD - 1);
    smp  = m_hist[1];
    for (int c = 0; c < 4; c++) begin
      logic acc;
      acc = 1'b0;
      if (tick) begin
        if (smp[c] != m_db[c]) begin
          m_run[c]++;
          if (m_run[c] == ST) begin
            acc = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      if (acc) begin
        m_held[c] = 0;
        if (smp[c]) begin
          m_rise[c] = 1'b1;
          m_rep[c]  = 1'b1;
        end else begin
          m_fall[c] = 1'b1;
        end
        m_db[c] = smp[c];
      end else if (MASK[c] && m_db[c] && tick) begin
        m_held[c]++;
        if (m_held[c] == RD || (m_held[c] > RD && ((m_held[c] - RD) % RP) == 0)) m_rep[c] = 1'b1;
      end
    end
    m_hist[1] = m_hist[0];
    m_hist[0] = r;
    m_cyc++;
  endtask

  function automatic logic [15:0] m_out();
    return {m_db, m_rise, m_fall, m_rep};
  endfunction

  // Drive one cycle of inputs at a falling edge and advance to the next falling edge.
  task automatic step(input logic rst_lvl_n, input logic [3:0] r);
    rst_n = rst_lvl_n;
    raw   = r;
    model_step(!rst_lvl_n, r);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'hF);
      n_checks++;
      if ({db, rise, fall, rep} !== 16'h0) begin
        n_errors++;
        $display("FAIL reset_hold cyc %0d: got %h want 0000", cyc, {db, rise, fall, rep});
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'h0);
      n_checks++;
      if ({db, rise, fall, rep} !== m_out()) begin
        n_errors++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", cyc, {db, rise, fall, rep}, m_out());
      end
    end
  endtask

  task automatic test_press();
    int n_rise = 0, n_rep = 0, n_fall = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 4'b0010);
      n_rise += int'(rise[1]);
      n_rep  += int'(rep[1]);
      n_checks++;
      if ({db, rise, fall, rep} !== m_out()) begin
        n_errors++;
        $display("FAIL press cyc %0d: got %h want %h", cyc, {db, rise, fall, rep}, m_out());
      end
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 4'b0000);
      n_fall += int'(fall[1]);
      n_checks++;
      if ({db, rise, fall, rep} !== m_out()) begin
        n_errors++;
        $display("FAIL press_rel cyc %0d: got %h want %h", cyc, {db, rise, fall, rep}, m_out());
      end
    end
    n_checks++;
    if (n_rise != 1 || n_rep != 1 || n_fall != 1) begin
      n_errors++;
      $display("FAIL press_counts: got rise=%0d rep=%0d fall=%0d want 1 1 1", n_rise, n_rep, n_fall);
    end
  endtask

  task automatic test_glitch();
    int n_ev = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, (i < 8) ? 4'b0100 : 4'b0000);
      n_ev += int'(db[2]) + int'(rise[2]) + int'(fall[2]) + int'(rep[2]);
      n_checks++;
      if ({db, rise, fall, rep} !== m_out()) begin
        n_errors++;
        $display("FAIL glitch cyc %0d: got %h want %h", cyc, {db, rise, fall, rep}, m_out());
      end
    end
    n_checks++;
    if (n_ev != 0) begin
      n_errors++;
      $display("FAIL glitch_reject: got %0d events on ch2 want 0", n_ev);
    end
  endtask

  task automatic test_repeat();
    int reps[$];
    int rise_cyc = -1, fall_cyc = -1, late_rep = 0, n_fall = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 4'b0001);
      if (rise[0]) rise_cyc = cyc;
      if (rep[0]) reps.push_back(cyc);
      n_checks++;
      if ({db, rise, fall, rep} !== m_out()) begin
        n_errors++;
        $display("FAIL repeat cyc %0d: got %h want %h", cyc, {db, rise, fall, rep}, m_out());
      end
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 4'b0000);
      if (fall[0]) begin
        fall_cyc = cyc;
        n_fall++;
      end
      if (rep[0] && (fall_cyc >= 0)) late_rep++;
      n_checks++;
      if ({db, rise, fall, rep} !== m_out()) begin
        n_errors++;
        $display("FAIL repeat_rel cyc %0d: got %h want %h", cyc, {db, rise, fall, rep}, m_out());
      end
    end
    n_checks++;
    if (reps.size() < 4 || reps[0] != rise_cyc) begin
      n_errors++;
      $display("FAIL repeat_first: got %0d pulses first at %0d want >=4 first at rise %0d",
               reps.size(), (reps.size() > 0) ? reps[0] : -1, rise_cyc);
    end else begin
      for (int k = 1; k < reps.size(); k++) begin
        int want;
        want = (k == 1) ? RD * TD : RP * TD;
        n_checks++;
        if (reps[k] - reps[k-1] != want) begin
          n_errors++;
          $display("FAIL repeat_gap %0d: got %0d cycles want %0d", k, reps[k] - reps[k-1], want);
        end
      end
    end
    n_checks++;
    if (n_fall != 1 || late_rep != 0) begin
      n_errors++;
      $display("FAIL repeat_stop: got fall=%0d late_rep=%0d want 1 0", n_fall, late_rep);
    end
  endtask

  task automatic test_simul();
    int n_all = 0, n_part = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, (i < 30) ? 4'hF : 4'h0);
      if (rise == 4'hF) n_all++;
      if (fall == 4'hF) n_all++;
      if ((rise != 4'h0 && rise != 4'hF) || (fall != 4'h0 && fall != 4'hF)) n_part++;
      n_checks++;
      if ({db, rise, fall, rep} !== m_out()) begin
        n_errors++;
        $display("FAIL simul cyc %0d: got %h want %h", cyc, {db, rise, fall, rep}, m_out());
      end
    end
    n_checks++;
    if (n_all != 2 || n_part != 0) begin
      n_errors++;
      $display("FAIL simul_together: got full=%0d partial=%0d want 2 0", n_all, n_part);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0, lat = -1, n_rise = 0;
    while (m_run[1] != 2 && guard < 40) begin
      step(1'b1, 4'b0010);
      guard++;
    end
    n_checks++;
    if (m_run[1] != 2 || db[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL rmid_setup: got db1=%b after %0d cycles want 0 mid-confirm", db[1], guard);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0010);
      n_checks++;
      if ({db, rise, fall, rep} !== 16'h0) begin
        n_errors++;
        $display("FAIL rmid_hold cyc %0d: got %h want 0000", cyc, {db, rise, fall, rep});
      end
    end
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 4'b0010);
      if (db[1] && lat < 0) lat = i;
      n_rise += int'(rise[1]);
      n_checks++;
      if ({db, rise, fall, rep} !== m_out()) begin
        n_errors++;
        $display("FAIL rmid cyc %0d: got %h want %h", cyc, {db, rise, fall, rep}, m_out());
      end
    end
    // Sync reaches 1 after 2 clocks; ticks land on clocks 4, 8, 12.
    n_checks++;
    if (lat != 3 * TD || n_rise != 1) begin
      n_errors++;
      $display("FAIL rmid_redebounce: got latency=%0d rises=%0d want %0d 1", lat, n_rise, 3 * TD);
    end
    for (int i = 0; i < 20; i++) step(1'b1, 4'b0000);
  endtask

  task automatic test_prescaler();
    logic [3:0] base;
    int         off [4];
    int         last = -1, n_tick = 0, bad_gap = 0, bad_db = 0;
    base = 4'b1010;
    for (int i = 0; i < 30; i++) step(1'b1, base);
    for (int i = 0; i < 420; i++) begin
      logic [3:0] g;
      if (i % 8 == 0) for (int c = 0; c < 4; c++) off[c] = int'($urandom_range(0, 7));
      g = '0;
      for (int c = 0; c < 4; c++) g[c] = (off[c] == i % 8) && ($urandom_range(0, 3) != 0);
      step(1'b1, base ^ g);
      if (dut.tick) begin
        if (last >= 0 && cyc - last != TD) bad_gap++;
        last = cyc;
        n_tick++;
      end
      if (db !== base) bad_db++;
      n_checks++;
      if ({db, rise, fall, rep} !== m_out()) begin
        n_errors++;
        $display("FAIL prescale cyc %0d: got %h want %h", cyc, {db, rise, fall, rep}, m_out());
      end
    end
    n_checks++;
    if (n_tick < 100 || bad_gap != 0) begin
      n_errors++;
      $display("FAIL tick_period: got %0d ticks %0d bad gaps want >=100 0", n_tick, bad_gap);
    end
    n_checks++;
    if (bad_db != 0) begin
      n_errors++;
      $display("FAIL glitch_db: got %0d cycles with db != %h want 0", bad_db, base);
    end
  endtask

  task automatic test_random();
    logic [3:0] lvl;
    int         hold [4];
    lvl = raw;
    for (int c = 0; c < 4; c++) hold[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          lvl[c]  = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 40));
        end
        hold[c]--;
      end
      step(1'b1, lvl);
      n_checks++;
      if ({db, rise, fall, rep} !== m_out()) begin
        n_errors++;
        $display("FAIL random cyc %0d: got %h want %h", cyc, {db, rise, fall, rep}, m_out());
      end
    end
  endtask

  initial begin
    model_step(1'b1, 4'h0);
    @(negedge clk);
    test_reset();
    test_press();
    test_glitch();
    test_repeat();
    test_simul();
    test_reset_mid();
    test_prescaler();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
